// File: rtl/flag_fifo_pkg.sv
// Shared defaults and flag bundle for the flag-based flow-control FIFO.
// Controller instantiation sites import the same default constants.
package flag_fifo_pkg;

  localparam int WIDTH_DEF      = 32;
  localparam int DEPTH_LOG2_DEF = 4;
  localparam int AF_MARGIN_DEF  = 4;
  localparam int AE_MARGIN_DEF  = 1;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RST = '{full: 1'b0, almost_full: 1'b0,
                                        empty: 1'b1, almost_empty: 1'b1};

endpackage

// File: rtl/flag_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// Only the read output register is reset; the array itself is never cleared.
module flag_fifo_ram #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/flag_fifo.sv
// Consumer-side FIFO of the flag flow-control link: explicit occupancy counter,
// registered flags from next-state occupancy, 1-cycle registered read data.
module flag_fifo
  import flag_fifo_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int AF_MARGIN  = AF_MARGIN_DEF,
  parameter int AE_MARGIN  = AE_MARGIN_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      din,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_MARGIN);

  function automatic fifo_flags_t flags_of(input logic [CW-1:0] occ);
    fifo_flags_t f;
    f.full         = (occ == FULL_LVL);
    f.almost_full  = (occ >= AF_LVL);
    f.empty        = (occ == '0);
    f.almost_empty = (occ <= AE_LVL);
    return f;
  endfunction

  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count_nxt;
  logic                  wr_acc_p0, rd_acc_p0;
  fifo_flags_t           flags_p1;
  logic                  vld_p1;
  logic [WIDTH-1:0]      rd_data_p1;

  // Stage p0: accept decisions use the current registered flags only
  assign wr_acc_p0 = wr_en && !flags_p1.full;
  assign rd_acc_p0 = rd_en && !flags_p1.empty;

  always_comb begin
    count_nxt = count;
    case ({wr_acc_p0, rd_acc_p0})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      flags_p1  <= FLAGS_RST;
      vld_p1    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc_p0) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc_p0) rd_ptr <= rd_ptr + 1'b1;
      count     <= count_nxt;
      flags_p1  <= flags_of(count_nxt);
      vld_p1    <= rd_acc_p0;
      overflow  <= overflow  | (wr_en && flags_p1.full);
      underflow <= underflow | (rd_en && flags_p1.empty);
    end
  end

  // Stage p1: storage read register feeds dout directly
  flag_fifo_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc_p0 && !reset),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (rd_acc_p0 && !reset),
    .raddr (rd_ptr),
    .rdata (rd_data_p1)
  );

  assign dout         = rd_data_p1;
  assign dout_valid   = vld_p1;
  assign full         = flags_p1.full;
  assign almost_full  = flags_p1.almost_full;
  assign empty        = flags_p1.empty;
  assign almost_empty = flags_p1.almost_empty;

endmodule

// File: tb/tb_flag_fifo.sv
// Directed bench for flag_fifo at DEPTH=16, AF_MARGIN=4, AE_MARGIN=1.
module tb_flag_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din;
  logic        wr_en, rd_en;
  logic        full, almost_full, empty, almost_empty;
  logic [31:0] dout;
  logic        dout_valid;
  logic [4:0]  count;
  logic        overflow, underflow;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  logic [31:0] v;
  logic [31:0] exp_d;

  always #5 clk = ~clk;

  flag_fifo #(
    .WIDTH(32), .DEPTH_LOG2(4), .AF_MARGIN(4), .AE_MARGIN(1)
  ) dut (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .full(full),
    .almost_full(almost_full), .rd_en(rd_en), .dout(dout),
    .dout_valid(dout_valid), .empty(empty), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] d);
    wr_en = 1'b1; din = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // model-driven cycle for the wrap test
  task automatic op(input bit w, input bit r);
    bit wa, ra;
    wa = w && (q.size() < 16);
    ra = r && (q.size() > 0);
    wr_en = w; rd_en = r; din = v;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    if (ra) begin
      exp_d = q.pop_front();
      chk("wrap_dout", dout, exp_d);
      chk("wrap_valid", 32'(dout_valid), 32'd1);
    end
    if (wa) begin
      q.push_back(v);
      v = v + 1;
    end
    chk("wrap_count", 32'(count), 32'(q.size()));
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_udf", 32'(underflow), 32'd0);

    // fill, watching the almost_full threshold
    for (int i = 1; i <= 16; i++) begin
      wr(32'(i));
      if (i == 1)  chk("w1_aempty", 32'(almost_empty), 32'd1);
      if (i == 2)  chk("w2_aempty", 32'(almost_empty), 32'd0);
      if (i == 11) chk("w11_afull", 32'(almost_full), 32'd0);
      if (i == 12) chk("w12_afull", 32'(almost_full), 32'd1);
      if (i == 12) chk("w12_count", 32'(count), 32'd12);
      if (i == 15) chk("w15_full", 32'(full), 32'd0);
    end
    chk("w16_full", 32'(full), 32'd1);
    chk("w16_count", 32'(count), 32'd16);
    chk("w16_ovf", 32'(overflow), 32'd0);

    wr(32'h11);
    chk("w17_count", 32'(count), 32'd16);
    chk("w17_ovf", 32'(overflow), 32'd1);

    for (int i = 1; i <= 16; i++) begin
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("rd_dout", dout, 32'(i));
      chk("rd_valid", 32'(dout_valid), 32'd1);
      if (i == 14) chk("r14_aempty", 32'(almost_empty), 32'd0);
      if (i == 15) chk("r15_aempty", 32'(almost_empty), 32'd1);
    end
    step();
    chk("idle_valid", 32'(dout_valid), 32'd0);
    chk("idle_hold", dout, 32'h10);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_udf", 32'(underflow), 32'd0);

    // simultaneous read/write at empty, mid-level and full
    do_reset();
    wr_en = 1'b1; rd_en = 1'b1; din = 32'h20;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("se_count", 32'(count), 32'd1);
    chk("se_udf", 32'(underflow), 32'd1);
    chk("se_valid", 32'(dout_valid), 32'd0);
    chk("se_empty", 32'(empty), 32'd0);
    for (int i = 1; i <= 7; i++) wr(32'h20 + 32'(i));
    chk("sm_pre", 32'(count), 32'd8);
    wr_en = 1'b1; rd_en = 1'b1; din = 32'h28;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("sm_count", 32'(count), 32'd8);
    chk("sm_dout", dout, 32'h20);
    chk("sm_valid", 32'(dout_valid), 32'd1);
    for (int i = 0; i < 8; i++) wr(32'h29 + 32'(i));
    chk("sf_pre_full", 32'(full), 32'd1);
    chk("sf_pre_ovf", 32'(overflow), 32'd0);
    wr_en = 1'b1; rd_en = 1'b1; din = 32'h31;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("sf_count", 32'(count), 32'd15);
    chk("sf_ovf", 32'(overflow), 32'd1);
    chk("sf_dout", dout, 32'h21);
    chk("sf_full", 32'(full), 32'd0);
    chk("sf_afull", 32'(almost_full), 32'd1);
    for (int k = 0; k < 15; k++) begin
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("sf_drain", dout, 32'h22 + 32'(k));
    end
    chk("sf_empty", 32'(empty), 32'd1);

    // pointer wrap with a reference queue
    do_reset();
    v = 32'h100;
    repeat (16) op(1'b1, 1'b0);
    chk("wrap_full", 32'(full), 32'd1);
    repeat (10) op(1'b0, 1'b1);
    repeat (10) op(1'b1, 1'b0);
    chk("wrap_full2", 32'(full), 32'd1);
    repeat (16) op(1'b0, 1'b1);
    chk("wrap_empty", 32'(empty), 32'd1);
    repeat (7) begin
      op(1'b1, 1'b0);
      op(1'b1, 1'b1);
    end
    repeat (7) op(1'b0, 1'b1);
    chk("wrap_end_empty", 32'(empty), 32'd1);

    // reset mid-operation discards in-flight traffic and stale contents
    for (int i = 0; i < 10; i++) wr(32'h40 + 32'(i));
    chk("mr_pre", 32'(count), 32'd10);
    reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1; din = 32'h99;
    step();
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk("mr_count", 32'(count), 32'd0);
    chk("mr_empty", 32'(empty), 32'd1);
    chk("mr_full", 32'(full), 32'd0);
    chk("mr_dout", dout, 32'd0);
    chk("mr_valid", 32'(dout_valid), 32'd0);
    wr(32'hAB);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("mr_new_dout", dout, 32'hAB);
    chk("mr_new_valid", 32'(dout_valid), 32'd1);
    chk("mr_new_empty", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
